fetch_queue: RTL and testbench

- Parametrised instruction fetch unit with a prefetch queue.
- Successor to the fixed address-register / incrementer / instruction-register fetch path in the cpu top.
- Issues sequential word fetches to memory over a req/ack handshake and buffers up to DEPTH {pc, instruction} pairs.
- Presents the queue head to the decoder with valid/ready; a branch (pc_load) flushes the queue and redirects fetch.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential req/ack word fetches into a DEPTH-entry
// prefetch queue of {pc, instruction}; pc_load flushes the queue and redirects.
module fetch_queue #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter int unsigned                DEPTH      = 4,
    parameter int unsigned                INCR       = 4,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_ack,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          ins_valid,
    input  logic                          ins_ready,
    output logic [DATA_WIDTH-1:0]         ins_data,
    output logic [ADDR_WIDTH-1:0]         ins_pc,
    input  logic                          pc_load,
    input  logic [ADDR_WIDTH-1:0]         pc_target,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   disc_addr_q, disc_addr_d;
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        count_next;
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   pcs_q  [DEPTH];
    logic                    push, pop;

    assign ins_valid  = (count_q != '0);
    assign ins_data   = data_q[head_q];
    assign ins_pc     = pcs_q[head_q];
    assign level      = count_q;
    assign mem_req    = (state_q == REQ) || (state_q == DISCARD);
    assign mem_addr   = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;

    assign pop        = ins_valid && ins_ready && !pc_load;
    assign push       = (state_q == REQ) && mem_ack && !pc_load;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;

        if (pc_load) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = pc_target;
            // An unacked request cannot be withdrawn; park its address and wait it out.
            if (state_q == REQ && !mem_ack) begin
                state_d     = DISCARD;
                disc_addr_d = fetch_pc_q;
            end else if (state_q == DISCARD && !mem_ack) begin
                state_d = DISCARD;
            end else begin
                state_d = REQ;
            end
        end else begin
            count_d = count_next;
            if (push) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INCR);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (count_next < CNT_W'(DEPTH)) state_d = REQ;
                end
                REQ: begin
                    if (mem_ack) state_d = (count_next < CNT_W'(DEPTH)) ? REQ : IDLE;
                end
                DISCARD: begin
                    if (mem_ack) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= mem_rdata;
            pcs_q[tail_q]  <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus pushes expected fetch
// addresses and instructions; negedge monitors pop and compare on handshakes.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_rdata;
    logic        ins_valid, ins_ready = 1'b0;
    logic [31:0] ins_data, ins_pc;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = '0;
    logic [2:0]  level;
    logic        ovr = 1'b0;
    logic [31:0] ovr_val = '0;

    logic        mem_req2, ins_valid2;
    logic [31:0] mem_addr2, ins_data2, ins_pc2;
    logic [2:0]  level2;

    int total = 0;
    int bad   = 0;
    int k2a   = 0;
    int k2p   = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_ins_q[$];

    always #5 clk = ~clk;

    assign mem_rdata = ovr ? ovr_val : {16'hC0DE, mem_addr[15:0]};

    fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .INCR(4),
                  .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_data(ins_data), .ins_pc(ins_pc),
        .pc_load(pc_load), .pc_target(pc_target), .level(level)
    );

    fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .INCR(4),
                  .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(1'b1), .mem_rdata(32'h1234_5678), .ins_valid(ins_valid2),
        .ins_ready(1'b1), .ins_data(ins_data2), .ins_pc(ins_pc2),
        .pc_load(1'b0), .pc_target(32'h0), .level(level2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wrap_seq(input int i);
        logic [31:0] t [3];
        t[0] = 32'hFFFF_FFF8;
        t[1] = 32'hFFFF_FFFC;
        t[2] = 32'h0000_0000;
        return t[i];
    endfunction

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (!reset && mem_req && mem_ack) begin
            if (exp_addr_q.size() == 0) chk("unexpected_fetch", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("fetch_addr", {32'h0, mem_addr}, {32'h0, exp_addr_q.pop_front()});
        end
        if (!reset && ins_valid && ins_ready && !pc_load) begin
            if (exp_ins_q.size() == 0) chk("unexpected_ins", {ins_pc, ins_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("ins_pc_data", {ins_pc, ins_data}, exp_ins_q.pop_front());
        end
    end

    // Wrap-around instance: first three fetch addresses and popped pcs.
    always @(negedge clk) begin
        if (!reset && mem_req2) begin
            if (k2a < 3) chk("wrap_addr", {32'h0, mem_addr2}, {32'h0, wrap_seq(k2a)});
            k2a++;
        end
        if (!reset && ins_valid2) begin
            if (k2p < 3) chk("wrap_pc", {32'h0, ins_pc2}, {32'h0, wrap_seq(k2p)});
            k2p++;
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst_ins_valid", {63'h0, ins_valid}, 64'h0);
        chk("rst_level", {61'h0, level}, 64'h0);

        // Fill the queue with ins_ready low
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(32'(4 * i));
        end
        reset = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("first_req", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h0});
        tick(); tick(); tick(); tick();
        chk("fill_level", {61'h0, level}, 64'd4);
        chk("fill_mem_req", {63'h0, mem_req}, 64'h0);
        chk("fill_head", {ins_pc, ins_data}, {32'h0, 32'hC0DE_0000});

        // One pop from a full queue
        exp_ins_q.push_back({32'h0, 32'hC0DE_0000});
        exp_addr_q.push_back(32'd16);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("pop_head_pc", {32'h0, ins_pc}, 64'd4);
        chk("pop_level", {61'h0, level}, 64'd3);
        chk("refetch_req", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'd16});
        tick();
        chk("refill_level", {61'h0, level}, 64'd4);
        chk("refill_mem_req", {63'h0, mem_req}, 64'h0);

        // Streaming: one instruction per cycle
        for (int i = 0; i < 6; i++) begin
            exp_ins_q.push_back({32'(4 + 4 * i), 32'hC0DE_0000 | 32'(4 + 4 * i)});
        end
        for (int i = 0; i < 5; i++) begin
            exp_addr_q.push_back(32'(20 + 4 * i));
        end
        ins_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_level", {61'h0, level}, 64'd3);
        end
        ins_ready = 1'b0;
        mem_ack = 1'b0;

        // Redirect while a request is outstanding
        pc_load = 1'b1;
        pc_target = 32'h100;
        tick();
        pc_load = 1'b0;
        chk("disc_flush_level", {61'h0, level}, 64'h0);
        chk("disc_req_held", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'd40});
        tick(); tick();
        chk("disc_still_held", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'd40});
        exp_addr_q.push_back(32'd40);
        ovr = 1'b1;
        ovr_val = 32'hDEAD_BEEF;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ovr = 1'b0;
        chk("disc_drop_level", {61'h0, level}, 64'h0);
        chk("redirect_req", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h100});
        exp_addr_q.push_back(32'h100);
        exp_ins_q.push_back({32'h100, 32'hC0DE_0100});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("after_redirect_level", {61'h0, level}, 64'h0);

        // pc_load together with mem_ack and ins_ready
        exp_addr_q.push_back(32'h104);
        mem_ack = 1'b1;
        tick();
        chk("pre_load_level", {61'h0, level}, 64'd1);
        exp_addr_q.push_back(32'h108);
        pc_load = 1'b1;
        pc_target = 32'h200;
        ins_ready = 1'b1;
        tick();
        pc_load = 1'b0;
        ins_ready = 1'b0;
        mem_ack = 1'b0;
        chk("load_level", {61'h0, level}, 64'h0);
        chk("load_valid", {63'h0, ins_valid}, 64'h0);
        chk("load_req", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h200});
        exp_addr_q.push_back(32'h200);
        exp_ins_q.push_back({32'h200, 32'hC0DE_0200});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        tick();

        chk("addr_sb_empty", 64'(exp_addr_q.size()), 64'h0);
        chk("ins_sb_empty", 64'(exp_ins_q.size()), 64'h0);
        chk("wrap_addr_seen", 64'(k2a >= 3), 64'h1);
        chk("wrap_pc_seen", 64'(k2p >= 3), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
